// File: rtl/clock_divider_prog_if.sv
// Control and output bundle of the programmable clock divider.
// The master side drives run/load requests; the slave side is the divider itself.
interface clock_divider_prog_if #(
  parameter int DIV_W = 8
);
  logic             en;
  logic [DIV_W-1:0] div_in;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic             running;
  logic [DIV_W-1:0] div_cur;
  logic             upd_done;
  logic             div_err;

  modport master (
    output en, div_in, div_load,
    input  clk_out, tick, running, div_cur, upd_done, div_err
  );

  modport slave (
    input  en, div_in, div_load,
    output clk_out, tick, running, div_cur, upd_done, div_err
  );
endinterface

// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider with 50% duty for even and odd divisors.
// Divisor changes and stop requests take effect only at output-period boundaries.
module clock_divider_prog #(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  clock_divider_prog_if.slave  bus,
  output logic                 dbg_state_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_cur_q;
  logic [DIV_W-1:0] pend_q;
  logic             pend_vld_q;
  logic             pos_q;
  logic             neg_q;
  logic             upd_done_q;
  logic             div_err_q;

  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W:0]   half_ceil;
  logic             load_ok;
  logic             load_bad;
  logic             at_bound;
  logic             apply;

  assign cnt_inc   = cnt_q + DIV_W'(1);
  // Extra bit keeps (N+1) from wrapping when N is the maximum divisor.
  assign half_ceil = ({1'b0, div_cur_q} + (DIV_W+1)'(1)) >> 1;
  assign load_ok   = bus.div_load && (bus.div_in >= DIV_W'(2));
  assign load_bad  = bus.div_load && (bus.div_in <  DIV_W'(2));
  assign at_bound  = (state_q == ST_RUN) && (cnt_q == (div_cur_q - DIV_W'(1)));
  assign apply     = pend_vld_q && ((state_q == ST_IDLE) || at_bound);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pos_q      <= 1'b0;
      div_cur_q  <= DIV_W'(DIV_RESET);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      upd_done_q <= 1'b0;
      div_err_q  <= 1'b0;
    end else begin
      upd_done_q <= 1'b0;
      div_err_q  <= load_bad;
      if (apply) begin
        div_cur_q  <= pend_q;
        pend_vld_q <= 1'b0;
        upd_done_q <= 1'b1;
      end
      // A load on the apply edge becomes the next pending value.
      if (load_ok) begin
        pend_q     <= bus.div_in;
        pend_vld_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          pos_q <= 1'b0;
          if (bus.en) begin
            state_q <= ST_RUN;
            pos_q   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (at_bound) begin
            cnt_q <= '0;
            if (bus.en) begin
              pos_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              pos_q   <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_inc;
            pos_q <= ({1'b0, cnt_inc} < half_ceil);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          pos_q   <= 1'b0;
        end
      endcase
    end
  end

  // Half-cycle delayed copy trims the odd-divisor high phase to N/2 clocks.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  assign bus.clk_out  = div_cur_q[0] ? (pos_q & neg_q) : pos_q;
  assign bus.tick     = (state_q == ST_RUN) && (cnt_q == '0);
  assign bus.running  = (state_q == ST_RUN);
  assign bus.div_cur  = div_cur_q;
  assign bus.upd_done = upd_done_q;
  assign bus.div_err  = div_err_q;
  assign dbg_state_o  = state_q;

endmodule
